dual_issue_ctrl: RTL and testbench

DUAL_ISSUE_CTRL -- requirements
Module: dual_issue_ctrl

---
 rtl/spu_pipe_pkg.sv | 20 ++
 rtl/reg_hazard_cmp.sv | 17 +
 rtl/dual_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dual_issue_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pipe_pkg.sv
// Shared pipeline definitions for the SPU dual-issue front end: control FSM
// states, default load latency and register-compare helper.
package spu_pipe_pkg;

  localparam int unsigned REG_W        = 7;
  localparam int unsigned LOAD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SPLIT = 2'd1,
    ST_STALL = 2'd2
  } ctrl_state_e;

  function automatic logic src_hit(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] ra,
                                   input logic [REG_W-1:0] rb);
    return (dst == ra) || (dst == rb);
  endfunction

endpackage

// File: rtl/reg_hazard_cmp.sv
// Compares one REG-stage source pair against both EX-stage load destinations.
module reg_hazard_cmp
  import spu_pipe_pkg::*;
(
  input  logic             ex1_load,
  input  logic [REG_W-1:0] ex1_dst,
  input  logic             ex2_load,
  input  logic [REG_W-1:0] ex2_dst,
  input  logic [REG_W-1:0] src_ra,
  input  logic [REG_W-1:0] src_rb,
  output logic             hit
);

  assign hit = (ex1_load & src_hit(ex1_dst, src_ra, src_rb)) |
               (ex2_load & src_hit(ex2_dst, src_ra, src_rb));

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue REG->EX control: load-use bubbles, in-pair conflict splitting,
// branch flush. Outputs are decided combinationally in the current cycle.
module dual_issue_ctrl
  import spu_pipe_pkg::*;
#(
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_REG1,
  input  logic             valid_REG2,
  input  logic             regWriteEnable_REG1,
  input  logic             regWriteEnable_REG2,
  input  logic             memRead_REG1,
  input  logic             memRead_REG2,
  input  logic             memWrite_REG1,
  input  logic             memWrite_REG2,
  input  logic [REG_W-1:0] writeRegister_REG1,
  input  logic [REG_W-1:0] writeRegister_REG2,
  input  logic [REG_W-1:0] readRegisterRA_REG1,
  input  logic [REG_W-1:0] readRegisterRA_REG2,
  input  logic [REG_W-1:0] readRegisterRB_REG1,
  input  logic [REG_W-1:0] readRegisterRB_REG2,
  input  logic             memRead_EX1,
  input  logic             memRead_EX2,
  input  logic             regWriteEnable_EX1,
  input  logic             regWriteEnable_EX2,
  input  logic [REG_W-1:0] writeRegister_EX1,
  input  logic [REG_W-1:0] writeRegister_EX2,
  input  logic             flush_EX,
  output logic             issue_EX1,
  output logic             issue_EX2,
  output logic             hold_REG,
  output logic [1:0]       ctrl_state
);

  localparam logic [2:0] STALL_CNT = 3'(LOAD_LAT - 1);
  localparam logic       MULTI_LAT = (LOAD_LAT > 1);

  ctrl_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pend2_q, pend2_d;
  logic        issue1_s, issue2_s, hold_s;
  logic        ex1_load_s, ex2_load_s, hit1_s, hit2_s;
  logic        haz1_s, haz2_s, pair_conflict_s;

  assign ex1_load_s = memRead_EX1 & regWriteEnable_EX1;
  assign ex2_load_s = memRead_EX2 & regWriteEnable_EX2;

  reg_hazard_cmp u_cmp1 (
    .ex1_load (ex1_load_s), .ex1_dst (writeRegister_EX1),
    .ex2_load (ex2_load_s), .ex2_dst (writeRegister_EX2),
    .src_ra   (readRegisterRA_REG1), .src_rb (readRegisterRB_REG1),
    .hit      (hit1_s)
  );

  reg_hazard_cmp u_cmp2 (
    .ex1_load (ex1_load_s), .ex1_dst (writeRegister_EX1),
    .ex2_load (ex2_load_s), .ex2_dst (writeRegister_EX2),
    .src_ra   (readRegisterRA_REG2), .src_rb (readRegisterRB_REG2),
    .hit      (hit2_s)
  );

  assign haz1_s = valid_REG1 & hit1_s;
  assign haz2_s = valid_REG2 & hit2_s;

  // Slot 2 cannot issue alongside slot 1 if it depends on it or contends for memory.
  assign pair_conflict_s = valid_REG1 & valid_REG2 &
      ((regWriteEnable_REG1 &
        src_hit(writeRegister_REG1, readRegisterRA_REG2, readRegisterRB_REG2)) |
       (regWriteEnable_REG1 & regWriteEnable_REG2 &
        (writeRegister_REG1 == writeRegister_REG2)) |
       ((memRead_REG1 | memWrite_REG1) & (memRead_REG2 | memWrite_REG2)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
      pend2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend2_q <= pend2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend2_d  = pend2_q;
    issue1_s = 1'b0;
    issue2_s = 1'b0;
    hold_s   = 1'b0;
    if (flush_EX) begin
      state_d = ST_RUN;
      cnt_d   = 3'd0;
      pend2_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (haz1_s | haz2_s) begin
            hold_s  = 1'b1;
            pend2_d = 1'b0;
            if (MULTI_LAT) begin
              state_d = ST_STALL;
              cnt_d   = STALL_CNT;
            end else begin
              state_d = ST_RUN;
            end
          end else if (pair_conflict_s) begin
            issue1_s = 1'b1;
            hold_s   = 1'b1;
            state_d  = ST_SPLIT;
          end else begin
            issue1_s = valid_REG1;
            issue2_s = valid_REG2;
          end
        end
        ST_SPLIT: begin
          if (haz2_s) begin
            hold_s  = 1'b1;
            pend2_d = 1'b1;
            if (MULTI_LAT) begin
              state_d = ST_STALL;
              cnt_d   = STALL_CNT;
            end else begin
              state_d = ST_SPLIT;
            end
          end else begin
            issue2_s = valid_REG2;
            pend2_d  = 1'b0;
            state_d  = ST_RUN;
          end
        end
        ST_STALL: begin
          hold_s = 1'b1;
          // A zero count is unreachable; treating it as the last bubble keeps the FSM from wrapping.
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            pend2_d = 1'b0;
            state_d = pend2_q ? ST_SPLIT : ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
          pend2_d = 1'b0;
        end
      endcase
    end
  end

  assign issue_EX1  = reset & issue1_s;
  assign issue_EX2  = reset & issue2_s;
  assign hold_REG   = reset & hold_s;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl; three instances (LOAD_LAT 1, 2, 3) share stimulus.
module tb_dual_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_REG1, valid_REG2;
  logic       regWriteEnable_REG1, regWriteEnable_REG2;
  logic       memRead_REG1, memRead_REG2, memWrite_REG1, memWrite_REG2;
  logic [6:0] writeRegister_REG1, writeRegister_REG2;
  logic [6:0] readRegisterRA_REG1, readRegisterRA_REG2;
  logic [6:0] readRegisterRB_REG1, readRegisterRB_REG2;
  logic       memRead_EX1, memRead_EX2, regWriteEnable_EX1, regWriteEnable_EX2;
  logic [6:0] writeRegister_EX1, writeRegister_EX2;
  logic       flush_EX;

  logic       ie1_1, ie2_1, hold_1;
  logic       ie1_2, ie2_2, hold_2;
  logic       ie1_3, ie2_3, hold_3;
  logic [1:0] cs_1, cs_2, cs_3;
  logic [4:0] o1, o2, o3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Observation word per instance: {ctrl_state, hold_REG, issue_EX1, issue_EX2}
  assign o1 = {cs_1, hold_1, ie1_1, ie2_1};
  assign o2 = {cs_2, hold_2, ie1_2, ie2_2};
  assign o3 = {cs_3, hold_3, ie1_3, ie2_3};

  dual_issue_ctrl #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .valid_REG1(valid_REG1), .valid_REG2(valid_REG2),
    .regWriteEnable_REG1(regWriteEnable_REG1), .regWriteEnable_REG2(regWriteEnable_REG2),
    .memRead_REG1(memRead_REG1), .memRead_REG2(memRead_REG2),
    .memWrite_REG1(memWrite_REG1), .memWrite_REG2(memWrite_REG2),
    .writeRegister_REG1(writeRegister_REG1), .writeRegister_REG2(writeRegister_REG2),
    .readRegisterRA_REG1(readRegisterRA_REG1), .readRegisterRA_REG2(readRegisterRA_REG2),
    .readRegisterRB_REG1(readRegisterRB_REG1), .readRegisterRB_REG2(readRegisterRB_REG2),
    .memRead_EX1(memRead_EX1), .memRead_EX2(memRead_EX2),
    .regWriteEnable_EX1(regWriteEnable_EX1), .regWriteEnable_EX2(regWriteEnable_EX2),
    .writeRegister_EX1(writeRegister_EX1), .writeRegister_EX2(writeRegister_EX2),
    .flush_EX(flush_EX),
    .issue_EX1(ie1_1), .issue_EX2(ie2_1), .hold_REG(hold_1), .ctrl_state(cs_1)
  );

  dual_issue_ctrl #(.LOAD_LAT(2)) dut2 (
    .clk(clk), .reset(reset),
    .valid_REG1(valid_REG1), .valid_REG2(valid_REG2),
    .regWriteEnable_REG1(regWriteEnable_REG1), .regWriteEnable_REG2(regWriteEnable_REG2),
    .memRead_REG1(memRead_REG1), .memRead_REG2(memRead_REG2),
    .memWrite_REG1(memWrite_REG1), .memWrite_REG2(memWrite_REG2),
    .writeRegister_REG1(writeRegister_REG1), .writeRegister_REG2(writeRegister_REG2),
    .readRegisterRA_REG1(readRegisterRA_REG1), .readRegisterRA_REG2(readRegisterRA_REG2),
    .readRegisterRB_REG1(readRegisterRB_REG1), .readRegisterRB_REG2(readRegisterRB_REG2),
    .memRead_EX1(memRead_EX1), .memRead_EX2(memRead_EX2),
    .regWriteEnable_EX1(regWriteEnable_EX1), .regWriteEnable_EX2(regWriteEnable_EX2),
    .writeRegister_EX1(writeRegister_EX1), .writeRegister_EX2(writeRegister_EX2),
    .flush_EX(flush_EX),
    .issue_EX1(ie1_2), .issue_EX2(ie2_2), .hold_REG(hold_2), .ctrl_state(cs_2)
  );

  dual_issue_ctrl #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .valid_REG1(valid_REG1), .valid_REG2(valid_REG2),
    .regWriteEnable_REG1(regWriteEnable_REG1), .regWriteEnable_REG2(regWriteEnable_REG2),
    .memRead_REG1(memRead_REG1), .memRead_REG2(memRead_REG2),
    .memWrite_REG1(memWrite_REG1), .memWrite_REG2(memWrite_REG2),
    .writeRegister_REG1(writeRegister_REG1), .writeRegister_REG2(writeRegister_REG2),
    .readRegisterRA_REG1(readRegisterRA_REG1), .readRegisterRA_REG2(readRegisterRA_REG2),
    .readRegisterRB_REG1(readRegisterRB_REG1), .readRegisterRB_REG2(readRegisterRB_REG2),
    .memRead_EX1(memRead_EX1), .memRead_EX2(memRead_EX2),
    .regWriteEnable_EX1(regWriteEnable_EX1), .regWriteEnable_EX2(regWriteEnable_EX2),
    .writeRegister_EX1(writeRegister_EX1), .writeRegister_EX2(writeRegister_EX2),
    .flush_EX(flush_EX),
    .issue_EX1(ie1_3), .issue_EX2(ie2_3), .hold_REG(hold_3), .ctrl_state(cs_3)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ev(input logic [1:0] st, input logic hold, input logic [1:0] iss);
    return {3'b000, st, hold, iss};
  endfunction

  task automatic clear_ex();
    memRead_EX1 = 1'b0; memRead_EX2 = 1'b0;
    regWriteEnable_EX1 = 1'b0; regWriteEnable_EX2 = 1'b0;
    writeRegister_EX1 = 7'd0; writeRegister_EX2 = 7'd0;
  endtask

  task automatic clear_reg();
    valid_REG1 = 1'b0; valid_REG2 = 1'b0;
    regWriteEnable_REG1 = 1'b0; regWriteEnable_REG2 = 1'b0;
    memRead_REG1 = 1'b0; memRead_REG2 = 1'b0;
    memWrite_REG1 = 1'b0; memWrite_REG2 = 1'b0;
    writeRegister_REG1 = 7'd0; writeRegister_REG2 = 7'd0;
    readRegisterRA_REG1 = 7'd0; readRegisterRA_REG2 = 7'd0;
    readRegisterRB_REG1 = 7'd0; readRegisterRB_REG2 = 7'd0;
  endtask

  // Independent pair: slot1 r6 <- r1,r2 ; slot2 r7 <- r5,r4
  task automatic set_indep();
    clear_reg();
    valid_REG1 = 1'b1; regWriteEnable_REG1 = 1'b1; writeRegister_REG1 = 7'd6;
    readRegisterRA_REG1 = 7'd1; readRegisterRB_REG1 = 7'd2;
    valid_REG2 = 1'b1; regWriteEnable_REG2 = 1'b1; writeRegister_REG2 = 7'd7;
    readRegisterRA_REG2 = 7'd5; readRegisterRB_REG2 = 7'd4;
  endtask

  // Dependent pair: slot1 writes r9, slot2 reads r9
  task automatic set_dep9();
    clear_reg();
    valid_REG1 = 1'b1; regWriteEnable_REG1 = 1'b1; writeRegister_REG1 = 7'd9;
    readRegisterRA_REG1 = 7'd1; readRegisterRB_REG1 = 7'd2;
    valid_REG2 = 1'b1; regWriteEnable_REG2 = 1'b1; writeRegister_REG2 = 7'd10;
    readRegisterRA_REG2 = 7'd9; readRegisterRB_REG2 = 7'd3;
  endtask

  task automatic ex1_load(input logic [6:0] dst);
    memRead_EX1 = 1'b1; regWriteEnable_EX1 = 1'b1; writeRegister_EX1 = dst;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      clear_reg(); clear_ex(); flush_EX = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; flush_EX = 1'b0;
    clear_ex(); set_indep();
    #2;
    check("rst_outs_l1", ev(cs_1, hold_1, {ie1_1, ie2_1}), ev(2'd0, 1'b0, 2'b00));
    check("rst_outs_l2", 8'(o2), ev(2'd0, 1'b0, 2'b00));
    step(); step();
    reset = 1'b1;
    idle(2);

    // Load into r5 in EX1, slot2 reads r5
    step(); set_indep(); clear_ex(); ex1_load(7'd5); #1;
    check("lu_a_l2", 8'(o2), ev(2'd0, 1'b1, 2'b00));
    check("lu_a_l1", 8'(o1), ev(2'd0, 1'b1, 2'b00));
    check("lu_a_l3", 8'(o3), ev(2'd0, 1'b1, 2'b00));
    step(); clear_ex(); #1;
    check("lu_b_l2", 8'(o2), ev(2'd2, 1'b1, 2'b00));
    check("lu_b_l1", 8'(o1), ev(2'd0, 1'b0, 2'b11));
    check("lu_b_l3", 8'(o3), ev(2'd2, 1'b1, 2'b00));
    step(); #1;
    check("lu_c_l2", 8'(o2), ev(2'd0, 1'b0, 2'b11));
    check("lu_c_l3", 8'(o3), ev(2'd2, 1'b1, 2'b00));
    idle(4);

    // RAW within the pair -> split
    step(); set_dep9(); #1;
    check("split_n_l2", 8'(o2), ev(2'd0, 1'b1, 2'b10));
    check("split_n_l1", 8'(o1), ev(2'd0, 1'b1, 2'b10));
    step(); regWriteEnable_EX1 = 1'b1; writeRegister_EX1 = 7'd9; #1;
    check("split_n1_l2", 8'(o2), ev(2'd1, 1'b0, 2'b01));
    step(); clear_reg(); clear_ex(); #1;
    check("split_n2_l2", 8'(o2), ev(2'd0, 1'b0, 2'b00));
    idle(3);

    // Slot1 load r3, slot2 reads r3, LOAD_LAT=3 -> 10, 00 x3, 01
    step(); clear_reg();
    valid_REG1 = 1'b1; regWriteEnable_REG1 = 1'b1; memRead_REG1 = 1'b1;
    writeRegister_REG1 = 7'd3; readRegisterRA_REG1 = 7'd1; readRegisterRB_REG1 = 7'd2;
    valid_REG2 = 1'b1; regWriteEnable_REG2 = 1'b1; writeRegister_REG2 = 7'd8;
    readRegisterRA_REG2 = 7'd3; readRegisterRB_REG2 = 7'd4;
    #1;
    check("ls_1_l3", 8'(o3), ev(2'd0, 1'b1, 2'b10));
    step(); ex1_load(7'd3); #1;
    check("ls_2_l3", 8'(o3), ev(2'd1, 1'b1, 2'b00));
    check("ls_2_l1", 8'(o1), ev(2'd1, 1'b1, 2'b00));
    step(); clear_ex(); #1;
    check("ls_3_l3", 8'(o3), ev(2'd2, 1'b1, 2'b00));
    check("ls_3_l2", 8'(o2), ev(2'd2, 1'b1, 2'b00));
    check("ls_3_l1", 8'(o1), ev(2'd1, 1'b0, 2'b01));
    step(); #1;
    check("ls_4_l3", 8'(o3), ev(2'd2, 1'b1, 2'b00));
    check("ls_4_l2", 8'(o2), ev(2'd1, 1'b0, 2'b01));
    step(); #1;
    check("ls_5_l3", 8'(o3), ev(2'd1, 1'b0, 2'b01));
    step(); clear_reg(); #1;
    check("ls_6_l3", 8'(o3), ev(2'd0, 1'b0, 2'b00));
    idle(4);

    // Flush in the second STALL cycle (LOAD_LAT=3)
    step(); set_indep(); clear_ex(); ex1_load(7'd5); #1;
    check("fl_a_l3", 8'(o3), ev(2'd0, 1'b1, 2'b00));
    step(); clear_ex(); #1;
    check("fl_b_l3", 8'(o3), ev(2'd2, 1'b1, 2'b00));
    step(); flush_EX = 1'b1; #1;
    check("fl_c_l3", 8'(o3), ev(2'd2, 1'b0, 2'b00));
    check("fl_c_l2", 8'(o2), ev(2'd0, 1'b0, 2'b00));
    step(); flush_EX = 1'b0; #1;
    check("fl_d_l3", 8'(o3), ev(2'd0, 1'b0, 2'b11));
    check("fl_d_cnt", 8'(dut3.cnt_q), 8'd0);
    idle(4);

    // Asynchronous reset in the middle of SPLIT
    step(); set_dep9(); #1;
    check("rs_1_l2", 8'(o2), ev(2'd0, 1'b1, 2'b10));
    step(); regWriteEnable_EX1 = 1'b1; writeRegister_EX1 = 7'd9; #1;
    check("rs_2_l2", 8'(o2), ev(2'd1, 1'b0, 2'b01));
    reset = 1'b0; #1;
    check("rs_async_l2", 8'(o2), ev(2'd0, 1'b0, 2'b00));
    check("rs_async_l3", 8'(o3), ev(2'd0, 1'b0, 2'b00));
    step(); reset = 1'b1; set_indep(); clear_ex(); #1;
    check("rs_rel_l2", 8'(o2), ev(2'd0, 1'b0, 2'b11));
    check("rs_rel_l3", 8'(o3), ev(2'd0, 1'b0, 2'b11));
    step(); #1;
    check("rs_rel2_l2", 8'(o2), ev(2'd0, 1'b0, 2'b11));
    idle(3);

    // Single-slot issue and memory contention split
    step(); clear_reg();
    valid_REG2 = 1'b1; regWriteEnable_REG2 = 1'b1; writeRegister_REG2 = 7'd7;
    readRegisterRA_REG2 = 7'd5; readRegisterRB_REG2 = 7'd4; #1;
    check("only2_l2", 8'(o2), ev(2'd0, 1'b0, 2'b01));
    step(); clear_reg();
    valid_REG1 = 1'b1; readRegisterRA_REG1 = 7'd1; #1;
    check("only1_l2", 8'(o2), ev(2'd0, 1'b0, 2'b10));
    step(); clear_reg();
    valid_REG1 = 1'b1; memWrite_REG1 = 1'b1; readRegisterRA_REG1 = 7'd1; readRegisterRB_REG1 = 7'd2;
    valid_REG2 = 1'b1; memWrite_REG2 = 1'b1; readRegisterRA_REG2 = 7'd3; readRegisterRB_REG2 = 7'd4;
    #1;
    check("mw_1_l2", 8'(o2), ev(2'd0, 1'b1, 2'b10));
    step(); #1;
    check("mw_2_l2", 8'(o2), ev(2'd1, 1'b0, 2'b01));
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
